// File: rtl/nabu_clk_reset_seq_if.sv
// Signal bundle between the reset sequencer and the rest of the system domain.
// The master side is the sequencer itself; the slave side is the PLL/core environment.
interface nabu_clk_reset_seq_if;
    logic       pll_locked;
    logic       lock_lost_clr;
    logic       sys_reset;
    logic       cen_vdp;
    logic       cen_cpu;
    logic       cen_psg;
    logic       lock_lost;
    logic [1:0] seq_state;

    modport master (
        input  pll_locked,
        input  lock_lost_clr,
        output sys_reset,
        output cen_vdp,
        output cen_cpu,
        output cen_psg,
        output lock_lost,
        output seq_state
    );

    modport slave (
        output pll_locked,
        output lock_lost_clr,
        input  sys_reset,
        input  cen_vdp,
        input  cen_cpu,
        input  cen_psg,
        input  lock_lost,
        input  seq_state
    );
endinterface

// File: rtl/nabu_clk_reset_seq.sv
// Reset sequencer and /4, /12, /24 clock-enable generator for the 42.95 MHz domain.
// Holds sys_reset until the PLL has been locked for RESET_HOLD cycles; drops back on lock loss.
module nabu_clk_reset_seq #(
    parameter int SYNC_STAGES = 2,
    parameter int RESET_HOLD  = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    nabu_clk_reset_seq_if.master bus
);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RUN       = 2'd2
    } seq_state_t;

    localparam int              HCW       = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
    localparam logic [HCW-1:0]  HOLD_LAST = HCW'(RESET_HOLD - 1);
    localparam logic [4:0]      DIV_LAST  = 5'd23;

    seq_state_t             state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lock_s;
    logic [HCW-1:0]         hold_cnt;
    logic [4:0]             div;
    logic [4:0]             div_inc;
    logic                   sys_reset_q;
    logic                   cen_vdp_q;
    logic                   cen_cpu_q;
    logic                   cen_psg_q;
    logic                   lock_lost_q;

    assign lock_s  = sync_q[SYNC_STAGES-1];
    assign div_inc = (div == DIV_LAST) ? 5'd0 : div + 5'd1;

    // Enables are decoded from the divider value being loaded, so each enable
    // is high exactly while div holds the matching phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q      <= '0;
            state       <= WAIT_LOCK;
            hold_cnt    <= '0;
            div         <= '0;
            sys_reset_q <= 1'b1;
            cen_vdp_q   <= 1'b0;
            cen_cpu_q   <= 1'b0;
            cen_psg_q   <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.pll_locked};

            if (bus.lock_lost_clr) begin
                lock_lost_q <= 1'b0;
            end

            case (state)
                WAIT_LOCK: begin
                    hold_cnt    <= '0;
                    div         <= '0;
                    sys_reset_q <= 1'b1;
                    cen_vdp_q   <= 1'b0;
                    cen_cpu_q   <= 1'b0;
                    cen_psg_q   <= 1'b0;
                    if (lock_s) begin
                        state <= HOLD;
                    end
                end

                HOLD: begin
                    if (!lock_s) begin
                        state       <= WAIT_LOCK;
                        hold_cnt    <= '0;
                        div         <= '0;
                        sys_reset_q <= 1'b1;
                        cen_vdp_q   <= 1'b0;
                        cen_cpu_q   <= 1'b0;
                        cen_psg_q   <= 1'b0;
                    end else begin
                        div       <= div_inc;
                        cen_vdp_q <= (div_inc[1:0] == 2'b11);
                        cen_cpu_q <= (div_inc == 5'd11) || (div_inc == 5'd23);
                        cen_psg_q <= (div_inc == 5'd23);
                        if (hold_cnt == HOLD_LAST) begin
                            state       <= RUN;
                            hold_cnt    <= '0;
                            sys_reset_q <= 1'b0;
                        end else begin
                            hold_cnt    <= hold_cnt + HCW'(1);
                            sys_reset_q <= 1'b1;
                        end
                    end
                end

                RUN: begin
                    if (!lock_s) begin
                        state       <= WAIT_LOCK;
                        hold_cnt    <= '0;
                        div         <= '0;
                        sys_reset_q <= 1'b1;
                        cen_vdp_q   <= 1'b0;
                        cen_cpu_q   <= 1'b0;
                        cen_psg_q   <= 1'b0;
                        // Overrides a same-cycle clear.
                        lock_lost_q <= 1'b1;
                    end else begin
                        div         <= div_inc;
                        sys_reset_q <= 1'b0;
                        cen_vdp_q   <= (div_inc[1:0] == 2'b11);
                        cen_cpu_q   <= (div_inc == 5'd11) || (div_inc == 5'd23);
                        cen_psg_q   <= (div_inc == 5'd23);
                    end
                end

                default: begin
                    state       <= WAIT_LOCK;
                    hold_cnt    <= '0;
                    div         <= '0;
                    sys_reset_q <= 1'b1;
                    cen_vdp_q   <= 1'b0;
                    cen_cpu_q   <= 1'b0;
                    cen_psg_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sys_reset = sys_reset_q;
    assign bus.cen_vdp   = cen_vdp_q;
    assign bus.cen_cpu   = cen_cpu_q;
    assign bus.cen_psg   = cen_psg_q;
    assign bus.lock_lost = lock_lost_q;
    assign bus.seq_state = state;

endmodule

// File: tb/tb_nabu_clk_reset_seq.sv
// Self-checking bench for nabu_clk_reset_seq: directed scenarios plus random lock/clear/reset
// traffic, compared every cycle against an elapsed-time model of the sequencer.
module tb_nabu_clk_reset_seq;

    localparam int SYNC = 2;
    localparam int RH   = 16;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    nabu_clk_reset_seq_if bus ();

    nabu_clk_reset_seq #(
        .SYNC_STAGES(SYNC),
        .RESET_HOLD (RH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: m_k is the 1-based cycle count since HOLD entry (0 while waiting for lock);
    // state and enables follow from it arithmetically.
    logic [SYNC-1:0] m_hist;
    int              m_k;
    logic            m_lost;

    always @(posedge clk) begin
        if (rst) begin
            m_hist <= '0;
            m_k    <= 0;
            m_lost <= 1'b0;
        end else begin
            m_hist <= {m_hist[SYNC-2:0], bus.pll_locked};
            if (m_k == 0)
                m_k <= m_hist[SYNC-1] ? 1 : 0;
            else if (!m_hist[SYNC-1])
                m_k <= 0;
            else
                m_k <= m_k + 1;
            if (m_k > RH && !m_hist[SYNC-1])
                m_lost <= 1'b1;
            else if (bus.lock_lost_clr)
                m_lost <= 1'b0;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        logic [6:0] exp_v;
        logic [6:0] act_v;
        int         st;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            st    = (m_k == 0) ? 0 : ((m_k <= RH) ? 1 : 2);
            exp_v = {st != 2, (m_k > 0) && (m_k % 4 == 0), (m_k > 0) && (m_k % 12 == 0),
                     (m_k > 0) && (m_k % 24 == 0), m_lost, 2'(st)};
            act_v = {bus.sys_reset, bus.cen_vdp, bus.cen_cpu, bus.cen_psg, bus.lock_lost,
                     bus.seq_state};
            n_tests++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL model {rst,vdp,cpu,psg,lost,state}: got %b expected %b at %0t",
                         act_v, exp_v, $time);
            end
        end
    endtask

    // Called at HOLD cycle 1; returns HOLD length and the HOLD cycle of the first cen_vdp.
    task automatic measure_hold(output int len, output int first_vdp);
        int i;
        i         = 1;
        first_vdp = 0;
        while (bus.sys_reset === 1'b1 && i <= 64) begin
            if (bus.cen_vdp === 1'b1 && first_vdp == 0) first_vdp = i;
            tick(1);
            i++;
        end
        len = i - 1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int len, fv, fc, fp, nv, nc, np, bad, hcnt;
        n_tests           = 0;
        n_fail            = 0;
        rst               = 1'b1;
        bus.pll_locked    = 1'b1;
        bus.lock_lost_clr = 1'b0;

        // Reset with lock already present
        tick(3);
        check("reset sys_reset", int'(bus.sys_reset), 1);
        check("reset enables", int'({bus.cen_vdp, bus.cen_cpu, bus.cen_psg}), 0);
        check("reset lock_lost", int'(bus.lock_lost), 0);
        check("reset seq_state", int'(bus.seq_state), 0);
        rst = 1'b0;
        tick(2);
        check("lock->hold before edge 2", int'(bus.seq_state), 0);
        tick(1);
        check("lock->hold at edge 2", int'(bus.seq_state), 1);

        // Release and cadence over HOLD plus 240 RUN cycles
        fv = 0; fc = 0; fp = 0; nv = 0; nc = 0; np = 0; bad = 0; hcnt = 0;
        for (int k = 1; k <= RH + 240; k++) begin
            if (bus.sys_reset === 1'b1) hcnt++;
            if (bus.cen_vdp === 1'b1 && fv == 0) fv = k;
            if (bus.cen_cpu === 1'b1 && fc == 0) fc = k;
            if (bus.cen_psg === 1'b1 && fp == 0) fp = k;
            if (k > RH) begin
                nv += int'(bus.cen_vdp === 1'b1);
                nc += int'(bus.cen_cpu === 1'b1);
                np += int'(bus.cen_psg === 1'b1);
            end
            if ((bus.cen_psg && !bus.cen_cpu) || (bus.cen_cpu && !bus.cen_vdp)) bad++;
            tick(1);
        end
        check("hold length", hcnt, 16);
        check("first cen_vdp", fv, 4);
        check("first cen_cpu", fc, 12);
        check("first cen_psg", fp, 24);
        check("cen_vdp count", nv, 60);
        check("cen_cpu count", nc, 20);
        check("cen_psg count", np, 10);
        check("coincidence violations", bad, 0);
        check("run state", int'(bus.seq_state), 2);

        // Lock lost in RUN
        bus.pll_locked = 1'b0;
        tick(2);
        check("run before loss edge", int'(bus.seq_state), 2);
        tick(1);
        check("loss sys_reset", int'(bus.sys_reset), 1);
        check("loss lock_lost", int'(bus.lock_lost), 1);
        check("loss enables", int'({bus.cen_vdp, bus.cen_cpu, bus.cen_psg}), 0);
        check("loss state", int'(bus.seq_state), 0);
        bus.pll_locked = 1'b1;
        tick(3);
        check("relock state", int'(bus.seq_state), 1);
        measure_hold(len, fv);
        check("relock hold length", len, 16);
        check("relock first cen_vdp", fv, 4);

        // Clear alone, then set/clear collision, then clear alone
        bus.lock_lost_clr = 1'b1;
        tick(1);
        bus.lock_lost_clr = 1'b0;
        check("clear alone", int'(bus.lock_lost), 0);
        bus.pll_locked = 1'b0;
        tick(2);
        bus.lock_lost_clr = 1'b1;
        tick(1);
        bus.lock_lost_clr = 1'b0;
        check("set beats clear", int'(bus.lock_lost), 1);
        tick(2);
        bus.lock_lost_clr = 1'b1;
        tick(1);
        bus.lock_lost_clr = 1'b0;
        check("clear after collision", int'(bus.lock_lost), 0);

        // Lock lost during HOLD
        bus.pll_locked = 1'b1;
        tick(3);
        check("hold entry", int'(bus.seq_state), 1);
        tick(7);
        bus.pll_locked = 1'b0;
        tick(3);
        check("hold loss state", int'(bus.seq_state), 0);
        check("hold loss lock_lost", int'(bus.lock_lost), 0);
        bus.pll_locked = 1'b1;
        tick(3);
        measure_hold(len, fv);
        check("hold restart length", len, 16);
        check("hold restart first cen_vdp", fv, 4);

        // rst in the middle of HOLD
        bus.pll_locked = 1'b0;
        tick(3);
        bus.pll_locked = 1'b1;
        tick(3);
        tick(9);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("mid-hold rst state", int'(bus.seq_state), 0);
        check("mid-hold rst sys_reset", int'(bus.sys_reset), 1);
        tick(3);
        check("post-rst hold entry", int'(bus.seq_state), 1);
        measure_hold(len, fv);
        check("post-rst hold length", len, 16);
        check("post-rst first cen_vdp", fv, 4);

        // Random lock drops, clears and resets against the model
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 39) == 0) bus.pll_locked = ~bus.pll_locked;
            bus.lock_lost_clr = ($urandom_range(0, 7) == 0);
            rst               = ($urandom_range(0, 299) == 0);
            tick(1);
        end
        rst               = 1'b0;
        bus.lock_lost_clr = 1'b0;
        tick(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
